substate_scheduler: RTL and testbench
=====================================

# substate_scheduler

Parent controller for the nested-FSM ("state within state") blocks. It owns the hold lines of up to NCH child sub-FSMs and runs the enabled children one at a time, in ascending index order. Each child is released, its completion handshake is awaited, its result is captured, and the child is forced back to its idle state before the next child is released. It sits directly above the child sequence-detector FSMs, replacing hand-wired state_select chaining.

## Interface
- NCH, 4, number of child FSMs (2..8)
- TMO_W, 8, width of the per-child watchdog counter
- TMO_MAX, 200, watchdog limit in cycles; must be < 2^TMO_W
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request a sequence; sampled only in IDLE
- mask  in  NCH  children to run; sampled with start
- child_done  in  NCH  per-child completion level (child's state_out)
- child_out  in  NCH  per-child result bit (child's out1)
- child_hold  out  NCH  1 holds the child in its idle/reset state; 0 lets it run
- busy  out  1  high from accept until return to IDLE
- active_idx  out  clog2(NCH)  index of the child currently released; 0 when idle
- result  out  NCH  captured child_out per child; held until the next accepted start
- seq_done  out  1  one-cycle pulse at sequence end
- timeout  out  1  sticky; a child was aborted by the watchdog

## Operation
- States: IDLE, RUN, RELEASE, DONE. All outputs are registered.
- Reset: state IDLE; child_hold all 1; busy 0; active_idx 0; result 0; seq_done 0; timeout 0; watchdog 0.
- IDLE:
  - child_hold is all 1.
  - On start=1, capture mask into mask_q, clear result and timeout, and set busy=1.
  - If mask≠0, go to RUN with active_idx set to the lowest set bit.
  - If mask=0, go to DONE.
- RUN:
  - Only child_hold[active_idx] is 0.
  - On child_done[active_idx]=1, set result[active_idx] to child_out[active_idx] and go to RELEASE.
  - child_done/child_out of non-active children are ignored.
- RELEASE (exactly 1 cycle):
  - child_hold is all 1, so the finished child returns to its idle state.
  - If mask_q has a set bit above active_idx, go to RUN with the next higher set index.
  - Otherwise go to DONE.
- DONE (exactly 1 cycle):
  - seq_done=1 and child_hold is all 1.
  - Then go to IDLE; busy drops on entry to IDLE.
- start while busy=1 is ignored; it is not queued.
- Changes to mask after accept have no effect.
- rst asserted in any state, including mid-RUN, forces the reset values on the next edge. Any partially captured result is discarded.
- A child whose child_done is already 1 on the first RUN cycle completes immediately; the minimum RUN length is 1 cycle.

## Timing
- start=1 sampled at edge E0. busy=1 and child_hold[first] = 0 from E0.
- If child_done[idx] is sampled high at edge Ek:
  - RELEASE holds from Ek to Ek+1;
  - the next child's hold drops from Ek+1.
- Fixed overhead: 1 cycle per child (RELEASE) plus 1 cycle at the end (DONE).
- With mask=0: seq_done is high from E0+1 to E0+2, and busy is low after E0+2.
- result[idx] is updated at the same edge RUN exits and is stable before seq_done.

## Configuration
- Macro: SUBSTATE_SCHED_TIMEOUT_EN.
- Defined:
  - The watchdog clears on RUN entry and increments each RUN cycle.
  - When it reaches TMO_MAX with no done, set result[active_idx]=0 and timeout=1, then go to RELEASE. The sequence continues with the remaining children.
  - If done and the limit occur on the same cycle, done wins.
- Not defined:
  - No watchdog logic is built; RUN waits indefinitely.
  - timeout is tied to 0.

## Test plan
- **Reset:** rst=1 for 2 cycles in any state -> child_hold=4'b1111, busy=0, result=0, seq_done=0, timeout=0.
- **Full sequence:** mask=4'b1011, children assert done after 3, 5 and 2 RUN cycles with child_out=1, 0, 1.
  - child_hold low order is 0, 1, 3; child 2 is never released.
  - result=4'b1001.
  - seq_done occurs 3+5+2+3+1 = 14 cycles after accept.
- **Empty mask:** start with mask=0 -> no child_hold drop; seq_done pulses at E0+1; busy is high for 2 cycles.
- **Ignored inputs:** start pulsed and mask changed during RUN -> ignored. Spurious child_done[2] while child 0 is active -> ignored; result[2] stays 0.
- **Reset mid-RUN:** rst during RUN of child 1 -> all holds 1 next edge. A following start with mask=4'b0010 runs cleanly.
- **Watchdog (SUBSTATE_SCHED_TIMEOUT_EN, TMO_MAX=10):** child 0 never signals done -> abort after 10 RUN cycles; timeout=1, result[0]=0. Child 1 then runs normally. Without the macro: busy stays 1 and timeout stays 0.

Source files
------------

// File: rtl/substate_scheduler_if.sv
// Handshake bundle between substate_scheduler and its surroundings: sequence
// request/status on one side, per-child hold/done/result lines on the other.
interface substate_scheduler_if #(
    parameter int NCH = 4
);
    localparam int IDX_W = $clog2(NCH);

    logic             start;
    logic [NCH-1:0]   mask;
    logic [NCH-1:0]   child_done;
    logic [NCH-1:0]   child_out;
    logic [NCH-1:0]   child_hold;
    logic             busy;
    logic [IDX_W-1:0] active_idx;
    logic [NCH-1:0]   result;
    logic             seq_done;
    logic             timeout;

    modport master (
        output start, mask, child_done, child_out,
        input  child_hold, busy, active_idx, result, seq_done, timeout
    );

    modport slave (
        input  start, mask, child_done, child_out,
        output child_hold, busy, active_idx, result, seq_done, timeout
    );
endinterface

// File: rtl/substate_scheduler.sv
// Parent controller that releases enabled child FSMs one at a time in ascending order.
// Optional per-child watchdog: define SUBSTATE_SCHED_TIMEOUT_EN.
module substate_scheduler #(
    parameter int NCH     = 4,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input logic                 clk,
    input logic                 rst,
    substate_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NCH);

    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("substate_scheduler: NCH must be 2..8");
    end
    if (TMO_MAX < 1 || TMO_MAX >= (1 << TMO_W)) begin : g_bad_tmo
        $error("substate_scheduler: TMO_MAX must be 1..2^TMO_W-1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t           r_state, w_state_n;
    logic [IDX_W-1:0] r_idx, w_idx_n;
    logic [NCH-1:0]   r_mask, w_mask_n;
    logic [NCH-1:0]   r_result, w_result_n;
    logic [NCH-1:0]   r_hold, w_hold_n;
    logic             r_busy, w_busy_n;
    logic             r_seq_done, w_seq_done_n;

    logic             w_first_vld, w_next_vld;
    logic [IDX_W-1:0] w_first_idx, w_next_idx;

`ifdef SUBSTATE_SCHED_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
    logic [TMO_W-1:0] r_wdog, w_wdog_n;
    logic             r_timeout, w_timeout_n;
`endif

    // Lowest requested child at accept, and next enabled child above the active one.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!w_first_vld && bus.mask[k]) begin
                w_first_vld = 1'b1;
                w_first_idx = IDX_W'(k);
            end
            if (!w_next_vld && r_mask[k] && (IDX_W'(k) > r_idx)) begin
                w_next_vld = 1'b1;
                w_next_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_idx_n      = r_idx;
        w_mask_n     = r_mask;
        w_result_n   = r_result;
        w_busy_n     = r_busy;
        w_seq_done_n = (r_state == S_DONE);
`ifdef SUBSTATE_SCHED_TIMEOUT_EN
        w_wdog_n     = r_wdog;
        w_timeout_n  = r_timeout;
`endif
        // busy falls together with the end of the seq_done pulse
        if (r_seq_done) begin
            w_busy_n = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start && !r_busy) begin
                    w_mask_n   = bus.mask;
                    w_result_n = '0;
                    w_busy_n   = 1'b1;
`ifdef SUBSTATE_SCHED_TIMEOUT_EN
                    w_timeout_n = 1'b0;
`endif
                    if (w_first_vld) begin
                        w_state_n = S_RUN;
                        w_idx_n   = w_first_idx;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (bus.child_done[r_idx]) begin
                    w_result_n[r_idx] = bus.child_out[r_idx];
                    w_state_n         = S_RELEASE;
                end
`ifdef SUBSTATE_SCHED_TIMEOUT_EN
                else if (r_wdog == TMO_LAST) begin
                    w_result_n[r_idx] = 1'b0;
                    w_timeout_n       = 1'b1;
                    w_state_n         = S_RELEASE;
                end else begin
                    w_wdog_n = r_wdog + TMO_W'(1);
                end
`endif
            end
            S_RELEASE: begin
                if (w_next_vld) begin
                    w_state_n = S_RUN;
                    w_idx_n   = w_next_idx;
                end else begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_idx_n   = '0;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

`ifdef SUBSTATE_SCHED_TIMEOUT_EN
        if (w_state_n == S_RUN && r_state != S_RUN) begin
            w_wdog_n = '0;
        end
`endif
        w_hold_n = '1;
        if (w_state_n == S_RUN) begin
            w_hold_n[w_idx_n] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_mask     <= '0;
            r_result   <= '0;
            r_hold     <= '1;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b0;
`ifdef SUBSTATE_SCHED_TIMEOUT_EN
            r_wdog     <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_mask     <= w_mask_n;
            r_result   <= w_result_n;
            r_hold     <= w_hold_n;
            r_busy     <= w_busy_n;
            r_seq_done <= w_seq_done_n;
`ifdef SUBSTATE_SCHED_TIMEOUT_EN
            r_wdog     <= w_wdog_n;
            r_timeout  <= w_timeout_n;
`endif
        end
    end

    assign bus.child_hold = r_hold;
    assign bus.busy       = r_busy;
    assign bus.active_idx = r_idx;
    assign bus.result     = r_result;
    assign bus.seq_done   = r_seq_done;
`ifdef SUBSTATE_SCHED_TIMEOUT_EN
    assign bus.timeout    = r_timeout;
`else
    assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_substate_scheduler.sv
// Directed bench for substate_scheduler; behavioural children complete after a
// programmable number of released cycles (latency 0 = never completes).
module tb_substate_scheduler;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    substate_scheduler_if #(.NCH(NCH)) bus ();

    substate_scheduler #(
        .NCH    (NCH),
        .TMO_W  (8),
        .TMO_MAX(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_errors = 0;
    int             lat [NCH];
    int             cnt [NCH];
    logic [NCH-1:0] cout;
    logic [NCH-1:0] sp_done;
    logic [NCH-1:0] w_done;
    logic [NCH-1:0] prev_hold = '1;
    int             rel_q [$];

    always @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            cnt[k] <= bus.child_hold[k] ? 0 : cnt[k] + 1;
        end
    end

    always_comb begin
        w_done = sp_done;
        for (int k = 0; k < NCH; k++) begin
            if (lat[k] != 0 && !bus.child_hold[k] && cnt[k] == lat[k] - 1) begin
                w_done[k] = 1'b1;
            end
        end
    end

    assign bus.child_done = w_done;
    assign bus.child_out  = cout;

    // Record the order in which children are released.
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (!bus.child_hold[k] && prev_hold[k]) begin
                rel_q.push_back(k);
            end
        end
        prev_hold <= bus.child_hold;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [NCH-1:0] m);
        bus.start = 1'b1;
        bus.mask  = m;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (bus.seq_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    function automatic int q_at(input int i);
        return (i < rel_q.size()) ? rel_q[i] : -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        int guard;
        bus.start = 1'b0;
        bus.mask  = '0;
        cout      = '0;
        sp_done   = '0;
        lat       = '{default: 0};

        // reset
        rst = 1'b1;
        tick();
        tick();
        chk("rst_hold",     32'(bus.child_hold), 'hF);
        chk("rst_busy",     32'(bus.busy), 0);
        chk("rst_result",   32'(bus.result), 0);
        chk("rst_seq_done", 32'(bus.seq_done), 0);
        chk("rst_timeout",  32'(bus.timeout), 0);
        chk("rst_idx",      32'(bus.active_idx), 0);
        rst = 1'b0;
        tick();

        // full sequence: mask 1011, latencies 3/5/2, outs 1/0/1
        lat = '{3, 5, 1, 2};
        cout = 4'b1101;
        rel_q.delete();
        start_seq(4'b1011);
        chk("full_busy",  32'(bus.busy), 1);
        chk("full_hold0", 32'(bus.child_hold), 'b1110);
        cyc = 0;
        while (bus.seq_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 3) chk("full_release0", 32'(bus.child_hold), 'hF);
            if (cyc == 4) begin
                chk("full_hold1",   32'(bus.child_hold), 'b1101);
                chk("full_idx1",    32'(bus.active_idx), 1);
                chk("full_res_mid", 32'(bus.result), 'b0001);
            end
            if (cyc == 10) chk("full_hold3", 32'(bus.child_hold), 'b0111);
        end
        chk("full_cycles", cyc, 14);
        chk("full_result", 32'(bus.result), 'b1001);
        chk("full_nrel",   rel_q.size(), 3);
        chk("full_rel_a",  q_at(0), 0);
        chk("full_rel_b",  q_at(1), 1);
        chk("full_rel_c",  q_at(2), 3);
        tick();
        chk("full_pulse_end", 32'(bus.seq_done), 0);
        chk("full_busy_end",  32'(bus.busy), 0);
        chk("full_res_held",  32'(bus.result), 'b1001);

        // empty mask
        rel_q.delete();
        start_seq(4'b0000);
        chk("empty_busy0", 32'(bus.busy), 1);
        chk("empty_sd0",   32'(bus.seq_done), 0);
        chk("empty_res",   32'(bus.result), 0);
        tick();
        chk("empty_sd1",   32'(bus.seq_done), 1);
        chk("empty_busy1", 32'(bus.busy), 1);
        tick();
        chk("empty_sd2",   32'(bus.seq_done), 0);
        chk("empty_busy2", 32'(bus.busy), 0);
        chk("empty_nrel",  rel_q.size(), 0);

        // ignored start/mask/spurious done during RUN
        lat = '{4, 0, 0, 0};
        cout = 4'b0101;
        rel_q.delete();
        start_seq(4'b0001);
        bus.start = 1'b1;
        bus.mask  = 4'b1111;
        sp_done   = 4'b0100;
        tick();
        tick();
        bus.start = 1'b0;
        bus.mask  = 4'b0000;
        sp_done   = 4'b0000;
        wait_done(2, cyc);
        chk("ign_cycles", cyc, 6);
        chk("ign_result", 32'(bus.result), 'b0001);
        chk("ign_nrel",   rel_q.size(), 1);
        chk("ign_rel_a",  q_at(0), 0);
        tick();
        chk("ign_busy_end", 32'(bus.busy), 0);
        tick();
        chk("ign_not_queued", 32'(bus.busy), 0);

        // reset while child 1 runs
        lat = '{2, 20, 0, 0};
        cout = 4'b1111;
        rel_q.delete();
        start_seq(4'b0011);
        guard = 0;
        while (bus.child_hold !== 4'b1101 && guard < 50) begin
            tick();
            guard++;
        end
        chk("rmr_reached", 32'(bus.child_hold), 'b1101);
        chk("rmr_partial", 32'(bus.result), 'b0001);
        tick();
        rst = 1'b1;
        tick();
        chk("rmr_hold",   32'(bus.child_hold), 'hF);
        chk("rmr_busy",   32'(bus.busy), 0);
        chk("rmr_result", 32'(bus.result), 0);
        chk("rmr_idx",    32'(bus.active_idx), 0);
        tick();
        rst = 1'b0;
        lat[1] = 3;
        rel_q.delete();
        start_seq(4'b0010);
        chk("rmr2_hold", 32'(bus.child_hold), 'b1101);
        wait_done(0, cyc);
        chk("rmr2_cycles", cyc, 5);
        chk("rmr2_result", 32'(bus.result), 'b0010);
        chk("rmr2_nrel",   rel_q.size(), 1);
        chk("rmr2_rel_a",  q_at(0), 1);
        tick();
        tick();

`ifdef SUBSTATE_SCHED_TIMEOUT_EN
        // child 0 never finishes; aborted after 10 RUN cycles
        lat = '{0, 2, 0, 0};
        start_seq(4'b0011);
        cyc = 0;
        while (bus.seq_done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
            if (cyc == 9) begin
                chk("wd_pre_tmo",  32'(bus.timeout), 0);
                chk("wd_pre_hold", 32'(bus.child_hold), 'b1110);
            end
            if (cyc == 10) begin
                chk("wd_tmo",      32'(bus.timeout), 1);
                chk("wd_rel_hold", 32'(bus.child_hold), 'hF);
            end
        end
        chk("wd_cycles", cyc, 15);
        chk("wd_result", 32'(bus.result), 'b0010);
        chk("wd_sticky", 32'(bus.timeout), 1);
        tick();
        tick();
        // done on the limit cycle wins
        lat = '{10, 0, 0, 0};
        start_seq(4'b0001);
        chk("wd_tmo_clr", 32'(bus.timeout), 0);
        wait_done(0, cyc);
        chk("wd_edge_cycles", cyc, 12);
        chk("wd_edge_result", 32'(bus.result), 'b0001);
        chk("wd_edge_tmo",    32'(bus.timeout), 0);
        tick();
`else
        // without the watchdog a silent child stalls the sequence
        lat = '{0, 0, 0, 0};
        start_seq(4'b0001);
        repeat (300) tick();
        chk("nowd_busy",    32'(bus.busy), 1);
        chk("nowd_timeout", 32'(bus.timeout), 0);
        chk("nowd_hold",    32'(bus.child_hold), 'b1110);
        chk("nowd_sd",      32'(bus.seq_done), 0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("nowd_rst_busy", 32'(bus.busy), 0);
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
